tw_slave_responder: RTL and testbench

- Target (responder) end of the team's 3-wire serial link. It receives frames driven by the 3-wire master: chip-select, serial clock and bidirectional data.
- Oversamples the link with the local in_clk and decodes R/W, address and data.
- Issues single-cycle write strobes and read requests on a simple local register bus.
- For reads, serialises the returned word back onto the shared data line.
- Sits in peripheral/test FPGAs that emulate a 3-wire device, and as loop-back for master verification.

---
 rtl/tw_slave_responder_pkg.sv | 21 ++
 rtl/tw_slave_responder_sync_edge.sv | 32 +++
 rtl/tw_slave_responder.sv | 169 ++++++++++++++++
 tb/tb_tw_slave_responder.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tw_slave_responder_pkg.sv
// Shared definitions for the 3-wire link.
// Field widths, R/W encoding and responder state codes.
package tw_slave_responder_pkg;

  localparam logic TW_RW_WRITE = 1'b1;
  localparam logic TW_RW_READ  = 1'b0;

  localparam int TW_ADDR_BITS = 9;
  localparam int TW_DATA_BITS = 16;

  typedef logic [2:0] tw_state_t;

  localparam tw_state_t ST_IDLE     = 3'd0;
  localparam tw_state_t ST_HDR      = 3'd1;
  localparam tw_state_t ST_WR_SHIFT = 3'd2;
  localparam tw_state_t ST_RD_FETCH = 3'd3;
  localparam tw_state_t ST_RD_WAIT  = 3'd4;
  localparam tw_state_t ST_RD_SHIFT = 3'd5;
  localparam tw_state_t ST_DONE     = 3'd6;

endpackage

// File: rtl/tw_slave_responder_sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses
// taken from the synchronised level.
module tw_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;
  logic              q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/tw_slave_responder.sv
// 3-wire link responder: decodes frames from the master
// and bridges them onto a local register bus.
module tw_slave_responder
  import tw_slave_responder_pkg::*;
#(
  parameter int ADDR_BITS   = TW_ADDR_BITS,
  parameter int DATA_BITS   = TW_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_req,
  input  logic [DATA_BITS-1:0] in_rd_data,
  output logic                 out_busy,
  output logic                 out_frame_err
);

  localparam int HDR_BITS = 1 + ADDR_BITS;
  localparam int CNT_MAX  =
    (HDR_BITS > DATA_BITS) ? HDR_BITS : DATA_BITS;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int SH_W     =
    (ADDR_BITS > DATA_BITS - 1) ? ADDR_BITS : DATA_BITS - 1;

  localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_BITS);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_BITS);

  tw_state_t state, nxt;

  logic ck_rise, ck_fall;
  logic cs_rise, cs_fall;
  logic d_s;
  logic oe;
  logic abortable;

  logic [SYNC_STAGES-1:0] dsync;
  logic [SH_W-1:0]        rx;
  logic [DATA_BITS-1:0]   tx;
  logic [CNT_W-1:0]       cnt;

  tw_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_ck (
    .clk  (in_clk),
    .rst  (in_rst),
    .d    (in_tw_clock),
    .rise (ck_rise),
    .fall (ck_fall)
  );

  tw_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs (
    .clk  (in_clk),
    .rst  (in_rst),
    .d    (in_tw_cs),
    .rise (cs_rise),
    .fall (cs_fall)
  );

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) dsync <= '0;
    else        dsync <= {dsync[SYNC_STAGES-2:0], io_tw_data};
  end

  assign d_s = dsync[SYNC_STAGES-1];

  assign abortable = (state != ST_IDLE) && (state != ST_DONE);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) state <= ST_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:
        if (cs_fall) nxt = ST_HDR;
      ST_HDR:
        if (cs_rise) nxt = ST_IDLE;
        else if (ck_rise && cnt == HDR_LAST)
          nxt = (rx[ADDR_BITS-1] == TW_RW_WRITE) ?
                ST_WR_SHIFT : ST_RD_FETCH;
      ST_WR_SHIFT:
        if (cs_rise) nxt = ST_IDLE;
        else if (ck_rise && cnt == DATA_LAST) nxt = ST_DONE;
      ST_RD_FETCH:
        if (cs_rise) nxt = ST_IDLE;
        else         nxt = ST_RD_WAIT;
      ST_RD_WAIT:
        if (cs_rise) nxt = ST_IDLE;
        else if (ck_fall) nxt = ST_RD_SHIFT;
      ST_RD_SHIFT:
        if (cs_rise) nxt = ST_IDLE;
        else if (ck_fall && cnt == DATA_END) nxt = ST_DONE;
      ST_DONE:
        if (cs_rise) nxt = ST_IDLE;
      default:
        nxt = ST_IDLE;
    endcase
  end

  // Enable is cut in the very cycle a cs rise is seen.
  always_comb begin
    out_busy = (state != ST_IDLE);
    oe       = (state == ST_RD_SHIFT) && !cs_rise;
  end

  assign io_tw_data = oe ? tx[DATA_BITS-1] : 1'bz;

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      rx            <= '0;
      tx            <= '0;
      cnt           <= '0;
      out_addr      <= '0;
      out_wr_data   <= '0;
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      out_frame_err <= cs_rise && abortable;
      unique case (state)
        ST_IDLE:
          if (cs_fall) begin
            rx  <= '0;
            cnt <= '0;
          end
        ST_HDR:
          if (!cs_rise && ck_rise) begin
            rx  <= {rx[SH_W-2:0], d_s};
            cnt <= cnt + CNT_W'(1);
            if (cnt == HDR_LAST) begin
              out_addr   <= {rx[ADDR_BITS-2:0], d_s};
              rx         <= '0;
              cnt        <= '0;
              out_rd_req <= (rx[ADDR_BITS-1] == TW_RW_READ);
            end
          end
        ST_WR_SHIFT:
          if (!cs_rise && ck_rise) begin
            rx  <= {rx[SH_W-2:0], d_s};
            cnt <= cnt + CNT_W'(1);
            if (cnt == DATA_LAST) begin
              out_wr_data   <= {rx[DATA_BITS-2:0], d_s};
              out_wr_strobe <= 1'b1;
            end
          end
        ST_RD_FETCH:
          tx <= in_rd_data;
        ST_RD_WAIT:
          if (!cs_rise && ck_fall) cnt <= CNT_W'(1);
        ST_RD_SHIFT:
          if (!cs_rise && ck_fall && cnt != DATA_END) begin
            tx  <= {tx[DATA_BITS-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tw_slave_responder.sv
// Scoreboard bench for the 3-wire responder: a bus-level
// master drives frames, a monitor checks bus-side events.
module tb_tw_slave_responder;

  localparam time H = 80ns;

  typedef struct {
    logic [8:0]  addr;
    logic [15:0] data;
  } wr_t;

  logic        in_clk;
  logic        in_rst;
  logic        tw_clk;
  logic        tw_cs;
  logic        m_oe;
  logic        m_bit;
  wire         tw_data;
  logic [8:0]  out_addr;
  logic [15:0] out_wr_data;
  logic        out_wr_strobe;
  logic        out_rd_req;
  logic [15:0] in_rd_data;
  logic        out_busy;
  logic        out_frame_err;

  int n_pass;
  int n_total;
  int exp_err;

  wr_t         exp_wr[$];
  logic [8:0]  exp_rd[$];
  logic [15:0] rsp_q[$];
  logic [15:0] mem[512];

  assign tw_data = m_oe ? m_bit : 1'bz;
  pullup pu (tw_data);

  tw_slave_responder dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_tw_clock   (tw_clk),
    .in_tw_cs      (tw_cs),
    .io_tw_data    (tw_data),
    .out_addr      (out_addr),
    .out_wr_data   (out_wr_data),
    .out_wr_strobe (out_wr_strobe),
    .out_rd_req    (out_rd_req),
    .in_rd_data    (in_rd_data),
    .out_busy      (out_busy),
    .out_frame_err (out_frame_err)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Bus-side monitor: pops the scoreboard on every DUT event.
  always @(negedge in_clk) begin
    if (!in_rst) begin
      if (out_wr_strobe) begin
        if (exp_wr.size() == 0) begin
          check("wr_strobe_unexpected", out_wr_strobe, 0);
        end else begin
          wr_t e;
          e = exp_wr.pop_front();
          check("wr_addr", out_addr, e.addr);
          check("wr_data", out_wr_data, e.data);
        end
      end
      if (out_rd_req) begin
        if (exp_rd.size() == 0) begin
          check("rd_req_unexpected", out_rd_req, 0);
        end else begin
          check("rd_addr", out_addr, exp_rd.pop_front());
          in_rd_data = rsp_q.pop_front();
        end
      end
      if (out_frame_err) begin
        if (exp_err == 0) begin
          check("frame_err_unexpected", out_frame_err, 0);
        end else begin
          exp_err--;
          check("frame_err", out_frame_err, 1);
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    m_oe  = 1'b1;
    m_bit = b;
    #(H);
    tw_clk = 1'b1;
    #(H);
    tw_clk = 1'b0;
  endtask

  task automatic drain();
    check("wr_pending", exp_wr.size(), 0);
    check("rd_pending", exp_rd.size(), 0);
    check("err_pending", exp_err, 0);
    check("busy_idle", out_busy, 0);
    check("line_idle_z", tw_data, 1);
  endtask

  // nd = data bits clocked before cs rises (16 = full frame).
  task automatic frame(input logic rw,
                       input logic [8:0] a,
                       input logic [15:0] wd,
                       input int nd,
                       input int extra);
    logic [9:0]  hdr;
    logic [15:0] exp;
    logic [15:0] got;
    hdr = {rw, a};
    exp = mem[a];
    got = '0;
    if (rw) begin
      if (nd == 16) begin
        exp_wr.push_back('{addr: a, data: wd});
        mem[a] = wd;
      end else begin
        exp_err++;
      end
    end else begin
      exp_rd.push_back(a);
      rsp_q.push_back(exp);
      if (nd < 16) exp_err++;
    end
    tw_cs = 1'b0;
    for (int i = 9; i >= 0; i--) send_bit(hdr[i]);
    if (!rw) m_oe = 1'b0;
    for (int i = 0; i < nd; i++) begin
      if (rw) begin
        send_bit(wd[15-i]);
      end else begin
        #(H);
        tw_clk = 1'b1;
        got[15-i] = tw_data;
        #(H);
        tw_clk = 1'b0;
      end
    end
    for (int i = 0; i < extra; i++) send_bit(1'($urandom));
    m_oe = 1'b0;
    #(H);
    check("busy_in_frame", out_busy, 1);
    if (!rw && nd == 16) check("rd_data", got, exp);
    if (rw || nd == 16) check("oe_released", tw_data, 1);
    tw_cs = 1'b1;
    #(4*H);
    drain();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] hdr;
    n_pass = 0;
    n_total = 0;
    exp_err = 0;
    tw_clk = 1'b0;
    tw_cs = 1'b1;
    m_oe = 1'b0;
    m_bit = 1'b0;
    in_rd_data = '0;
    for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
    in_rst = 1'b0;
    #2;
    in_rst = 1'b1;
    repeat (4) @(negedge in_clk);
    check("rst_addr", out_addr, 0);
    check("rst_wr_data", out_wr_data, 0);
    check("rst_wr_strobe", out_wr_strobe, 0);
    check("rst_rd_req", out_rd_req, 0);
    check("rst_busy", out_busy, 0);
    check("rst_frame_err", out_frame_err, 0);
    check("rst_line_z", tw_data, 1);
    in_rst = 1'b0;
    repeat (4) @(negedge in_clk);

    frame(1'b1, 9'h0A5, 16'hBEEF, 16, 0);
    check("wr_data_held", out_wr_data, 16'hBEEF);
    check("wr_addr_held", out_addr, 9'h0A5);

    mem[9'h1FF] = 16'h1234;
    frame(1'b0, 9'h1FF, 16'h0000, 16, 0);

    frame(1'b1, 9'h003, 16'($urandom), 5, 0);
    frame(1'b1, 9'h004, 16'h5555, 16, 0);

    frame(1'b1, 9'h010, 16'h00FF, 16, 0);
    frame(1'b0, 9'h010, 16'h0000, 16, 0);

    frame(1'b1, 9'h077, 16'hC3A5, 16, 3);
    check("extra_wr_data", out_wr_data, 16'hC3A5);

    // Reset while the responder is driving a zero bit.
    mem[9'h055] = 16'h0000;
    exp_rd.push_back(9'h055);
    rsp_q.push_back(16'h0000);
    hdr = {1'b0, 9'h055};
    tw_cs = 1'b0;
    for (int i = 9; i >= 0; i--) send_bit(hdr[i]);
    m_oe = 1'b0;
    repeat (4) begin
      #(H);
      tw_clk = 1'b1;
      #(H);
      tw_clk = 1'b0;
    end
    #(H/2);
    check("rd_drive_low", tw_data, 0);
    in_rst = 1'b1;
    #1;
    check("mid_rst_line_z", tw_data, 1);
    check("mid_rst_busy", out_busy, 0);
    check("mid_rst_addr", out_addr, 0);
    check("mid_rst_wr_data", out_wr_data, 0);
    check("mid_rst_rd_req", out_rd_req, 0);
    tw_cs = 1'b1;
    #(4*H);
    @(negedge in_clk);
    in_rst = 1'b0;
    #(4*H);
    drain();

    mem[9'h001] = 16'hA5A5;
    frame(1'b0, 9'h001, 16'h0000, 16, 0);

    for (int k = 0; k < 24; k++) begin
      logic        rw;
      logic [8:0]  a;
      int          nd;
      rw = 1'($urandom);
      a  = 9'($urandom);
      nd = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 16;
      frame(rw, a, 16'($urandom), nd, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
